// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target byte engine.
package i2c_pkg;

    localparam int I2C_BYTE_W = 8;
    localparam int I2C_ADDR_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE_BYTE,
        WRITE_ACK,
        READ_BYTE,
        READ_ACK,
        IGNORE
    } state_t;

endpackage

// File: rtl/i2c_target_if.sv
// Bus pads plus the strobe/data handshake towards i2c_fsm.
interface i2c_target_if;
    import i2c_pkg::*;

    logic                  scl_in;
    logic                  sda_in;
    logic                  sda_oe;
    logic                  i2c_write;
    logic                  i2c_read;
    logic                  i2c_write_valid;
    logic [I2C_BYTE_W-1:0] i2c_write_data;
    logic [I2C_BYTE_W-1:0] i2c_read_data;
    logic                  i2c_read_ready;

    modport slave (
        input  scl_in, sda_in, i2c_read_data,
        output sda_oe, i2c_write, i2c_read, i2c_write_valid, i2c_write_data, i2c_read_ready
    );

    modport master (
        output scl_in, sda_in, i2c_read_data,
        input  sda_oe, i2c_write, i2c_read, i2c_write_valid, i2c_write_data, i2c_read_ready
    );

endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter; idles high.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic filt
);

    localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

    logic       sync_p0;
    logic       sync_p1;
    logic [3:0] cnt;

    // The filtered value flips on the FILTER_LEN-th consecutive differing sample.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            cnt     <= 4'd0;
            filt    <= 1'b1;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            if (sync_p1 == filt) begin
                cnt <= 4'd0;
            end else if (cnt == LAST) begin
                filt <= sync_p1;
                cnt  <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target: filtered line conditioning, START/STOP detection, address match
// and byte shifting, producing single-cycle strobes for i2c_fsm.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] ADDRESS    = 7'h2F,
    parameter int                    FILTER_LEN = 3
) (
    input  logic         clk,
    input  logic         resetn,
    i2c_target_if.slave  bus
);

    logic                  scl_f, sda_f, scl_q, sda_q;
    logic                  scl_rise, scl_fall, start_c, stop_c;
    state_t                state;
    logic [3:0]            bit_cnt;
    logic [I2C_BYTE_W-1:0] shift, tx, wdata;
    logic                  rw, nack, oe;
    logic                  wr_p, rd_p, wv_p, rr_p;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (.clk(clk), .resetn(resetn), .raw(bus.scl_in), .filt(scl_f));
    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (.clk(clk), .resetn(resetn), .raw(bus.sda_in), .filt(sda_f));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign scl_rise = scl_f & ~scl_q;
    assign scl_fall = ~scl_f & scl_q;
    assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            shift   <= '0;
            tx      <= '0;
            wdata   <= '0;
            rw      <= 1'b0;
            nack    <= 1'b1;
            oe      <= 1'b0;
            wr_p    <= 1'b0;
            rd_p    <= 1'b0;
            wv_p    <= 1'b0;
            rr_p    <= 1'b0;
        end else begin
            wr_p <= 1'b0;
            rd_p <= 1'b0;
            wv_p <= 1'b0;
            rr_p <= 1'b0;
            // Bus conditions override whatever the byte engine is doing.
            if (start_c) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                oe      <= 1'b0;
            end else if (stop_c) begin
                state <= IDLE;
                oe    <= 1'b0;
            end else begin
                case (state)
                    ADDR, WRITE_BYTE: begin
                        if (scl_rise) begin
                            shift   <= {shift[I2C_BYTE_W-2:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (state == WRITE_BYTE) begin
                                wdata <= shift;
                                wv_p  <= 1'b1;
                                oe    <= 1'b1;
                                state <= WRITE_ACK;
                            end else if (shift[7:1] == ADDRESS) begin
                                rw    <= shift[0];
                                wr_p  <= ~shift[0];
                                rd_p  <= shift[0];
                                oe    <= 1'b1;
                                state <= ADDR_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                tx      <= bus.i2c_read_data;
                                rr_p    <= 1'b1;
                                oe      <= ~bus.i2c_read_data[7];
                                bit_cnt <= 4'd1;
                                state   <= READ_BYTE;
                            end else begin
                                oe    <= 1'b0;
                                state <= WRITE_BYTE;
                            end
                        end
                    end
                    WRITE_ACK: begin
                        if (scl_fall) begin
                            oe      <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= WRITE_BYTE;
                        end
                    end
                    READ_BYTE: begin
                        // bit_cnt counts bits already placed on the bus.
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                oe    <= 1'b0;
                                state <= READ_ACK;
                            end else begin
                                oe      <= ~tx[6];
                                tx      <= {tx[I2C_BYTE_W-2:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise) begin
                            nack <= sda_f;
                        end else if (scl_fall) begin
                            if (!nack) begin
                                tx      <= bus.i2c_read_data;
                                rr_p    <= 1'b1;
                                oe      <= ~bus.i2c_read_data[7];
                                bit_cnt <= 4'd1;
                                state   <= READ_BYTE;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    default: oe <= 1'b0;
                endcase
            end
        end
    end

    assign bus.sda_oe          = oe;
    assign bus.i2c_write       = wr_p;
    assign bus.i2c_read        = rd_p;
    assign bus.i2c_write_valid = wv_p;
    assign bus.i2c_write_data  = wdata;
    assign bus.i2c_read_ready  = rr_p;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C master, a transaction-level model that
// queues expected strobes, and a monitor that pops them as the DUT pulses.
module tb_i2c_target;

    localparam int Q = 8;
    localparam logic [6:0] TADDR = 7'h2F;
    localparam logic [2:0] K_W = 3'd1, K_R = 3'd2, K_WV = 3'd3, K_RR = 3'd4;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic scl_m = 1'b1, sda_m = 1'b1, scl_g = 1'b0, sda_g = 1'b0;
    logic glitch_en = 1'b0;
    logic oe_seen = 1'b0;
    int   errors = 0, checks = 0;
    int   rd_exp = 0;
    ev_t  sbq[$];
    logic [7:0] rd_vals[64];
    logic [7:0] wbuf[8];

    always #5 clk = ~clk;

    i2c_target_if bus();

    assign bus.scl_in = scl_m & ~scl_g;
    assign bus.sda_in = sda_m & ~sda_g & ~bus.sda_oe;

    i2c_target #(.ADDRESS(TADDR), .FILTER_LEN(3)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Read-data source: next byte is presented after each capture pulse.
    initial begin
        int idx;
        idx = 0;
        rd_vals[0] = 8'hBC;
        rd_vals[1] = 8'hCF;
        rd_vals[2] = 8'h96;
        rd_vals[3] = 8'h3C;
        for (int i = 4; i < 64; i++) rd_vals[i] = 8'($urandom);
        bus.i2c_read_data = rd_vals[0];
        forever begin
            @(negedge clk);
            if (bus.i2c_read_ready && idx < 63) begin
                idx++;
                bus.i2c_read_data = rd_vals[idx];
            end
        end
    end

    // Monitor: every strobe must match the head of the expected queue.
    initial begin
        int   n;
        logic [2:0] kind;
        logic oe_prev;
        ev_t  e;
        oe_prev = 1'b0;
        forever begin
            @(negedge clk);
            n = int'(bus.i2c_write) + int'(bus.i2c_read) + int'(bus.i2c_write_valid) + int'(bus.i2c_read_ready);
            if (bus.sda_oe) oe_seen = 1'b1;
            if (bus.sda_oe && !oe_prev) chk("oe_rise_scl_low", int'(scl_m), 0);
            oe_prev = bus.sda_oe;
            if (n > 0) begin
                kind = bus.i2c_write ? K_W : bus.i2c_read ? K_R : bus.i2c_write_valid ? K_WV : K_RR;
                if (n > 1) begin
                    chk("one_strobe", n, 1);
                end else if (sbq.size() == 0) begin
                    chk("unexpected_strobe", int'(kind), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("strobe_kind", int'(kind), int'(e.kind));
                    if (e.kind == K_WV) chk("write_data", int'(bus.i2c_write_data), int'(e.data));
                end
            end
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b, output logic rb);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        rb = sda_m & ~bus.sda_oe;
        if (glitch_en) begin
            wait_clk(1);
            scl_g = 1'b1;
            wait_clk(2);
            scl_g = 1'b0;
            wait_clk(1);
            sda_g = 1'b1;
            wait_clk(2);
            sda_g = 1'b0;
            wait_clk(Q - 6);
        end else begin
            wait_clk(Q);
        end
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic rb;
        for (int i = 7; i >= 0; i--) send_bit(d[i], rb);
        send_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack_it, output logic [7:0] d);
        logic rb;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, rb);
            d[i] = rb;
        end
        send_bit(nack_it, rb);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    // Reference model: an addressed target raises one R/W strobe, one strobe per
    // byte (writes carry data), ACKs writes, and serves read bytes in order.
    task automatic txn(input logic [7:0] addr, input int n, input logic do_stop);
        logic match, ack;
        logic [7:0] got, exp;
        match = (addr[7:1] == TADDR);
        if (match) begin
            sbq.push_back('{kind: (addr[0] ? K_R : K_W), data: 8'h00});
            for (int k = 0; k < n; k++)
                sbq.push_back('{kind: (addr[0] ? K_RR : K_WV), data: (addr[0] ? 8'h00 : wbuf[k])});
        end
        bus_start();
        send_byte(addr, ack);
        chk("addr_ack", int'(ack), match ? 0 : 1);
        for (int k = 0; k < n; k++) begin
            if (!addr[0]) begin
                send_byte(wbuf[k], ack);
                chk("write_ack", int'(ack), match ? 0 : 1);
            end else begin
                exp = match ? rd_vals[rd_exp] : 8'hFF;
                if (match) rd_exp++;
                recv_byte(k == n - 1, got);
                chk("read_byte", int'(got), int'(exp));
            end
        end
        if (do_stop) bus_stop();
    endtask

    initial begin
        logic ack;
        logic [7:0] a;
        wait_clk(4);
        chk("rst_sda_oe", int'(bus.sda_oe), 0);
        chk("rst_write", int'(bus.i2c_write), 0);
        chk("rst_read", int'(bus.i2c_read), 0);
        chk("rst_wvalid", int'(bus.i2c_write_valid), 0);
        chk("rst_rready", int'(bus.i2c_read_ready), 0);
        chk("rst_wdata", int'(bus.i2c_write_data), 0);
        resetn = 1'b1;
        wait_clk(2 * Q);

        wbuf[0] = 8'h42; wbuf[1] = 8'h17;
        txn(8'h5E, 2, 1'b1);
        txn(8'h5F, 2, 1'b1);
        chk("nack_release", int'(bus.sda_oe), 0);

        wbuf[0] = 8'h42;
        oe_seen = 1'b0;
        txn(8'h60, 1, 1'b1);
        chk("wrong_addr_oe", int'(oe_seen), 0);

        wbuf[0] = 8'h01;
        txn(8'h5E, 1, 1'b0);
        txn(8'h5F, 1, 1'b1);

        scl_g = 1'b1; wait_clk(2); scl_g = 1'b0; wait_clk(Q);
        sda_g = 1'b1; wait_clk(2); sda_g = 1'b0; wait_clk(Q);
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        glitch_en = 1'b1;
        txn(8'h5E, 2, 1'b0);
        glitch_en = 1'b0;
        bus_stop();

        // Reset while the target is driving a 0 data bit.
        sbq.push_back('{kind: K_R, data: 8'h00});
        sbq.push_back('{kind: K_RR, data: 8'h00});
        bus_start();
        send_byte(8'h5F, ack);
        chk("rst_test_ack", int'(ack), 0);
        rd_exp++;
        chk("drive_zero_bit", int'(bus.sda_oe), 1);
        resetn = 1'b0;
        wait_clk(1);
        chk("midrst_sda_oe", int'(bus.sda_oe), 0);
        chk("midrst_strobes", int'(bus.i2c_write | bus.i2c_read | bus.i2c_write_valid | bus.i2c_read_ready), 0);
        chk("midrst_wdata", int'(bus.i2c_write_data), 0);
        resetn = 1'b1;
        wait_clk(Q);
        bus_stop();
        wbuf[0] = 8'hC3;
        txn(8'h5E, 1, 1'b1);

        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 3) != 0) begin
                a = {TADDR, 1'($urandom)};
            end else begin
                a = 8'($urandom);
                if (a[7:1] == TADDR) a[7] = ~a[7];
            end
            for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
            txn(a, $urandom_range(1, 3), (t == 7) ? 1'b1 : 1'($urandom));
        end

        wait_clk(4 * Q);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
